delay_timer_arbiter: RTL

- Shares one down-counting delay timer between NREQ requesters; each requester asks for a delay of req_len cycles.
- Round-robin arbitration selects one requester, loads the counter, sequences the countdown and returns a one-cycle done pulse to the winner.
- Sits beside the team's counter datapaths as the scheduler that hands out a single timing resource instead of instantiating one counter per client.

---
 rtl/delay_timer_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/delay_timer_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/delay_timer_pkg.sv
// Shared definitions for the delay timer arbiter: FSM encoding and default sizes.
package delay_timer_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after the pointer, wrapping.
module rr_arbiter
   import delay_timer_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   pointer,
   output logic [PW-1:0]   winner,
   output logic            valid
);

   logic [PW-1:0] idx;

   // Scan from farthest to nearest slot so the nearest set request after the pointer wins last
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = PW'((int'(pointer) + k) % NREQ);
         if (req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/delay_timer_arbiter.sv
// One shared down-counting delay timer handed out to NREQ requesters in round-robin order.
module delay_timer_arbiter
   import delay_timer_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_len,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [WIDTH-1:0]      count
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t                       state, state_nxt;
   logic [PW-1:0]                pointer;
   logic [PW-1:0]                arb_win;
   logic                         arb_vld;
   logic [NREQ-1:0]              win_oh;
   logic [NREQ-1:0][WIDTH-1:0]   lens;
   logic                         req_held;

   assign lens     = req_len;
   // After a grant the pointer is the current owner, so it doubles as the winner index
   assign req_held = req[pointer];

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req     (req),
      .pointer (pointer),
      .winner  (arb_win),
      .valid   (arb_vld)
   );

   // Decode the arbiter pick into the one-hot grant vector
   always_comb begin
      win_oh          = '0;
      win_oh[arb_win] = 1'b1;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state: dropping the owner's request aborts; count reaching zero completes
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (arb_vld) state_nxt = RUN;
         RUN: begin
            if (!req_held)          state_nxt = IDLE;
            else if (count == '0)   state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = (state != IDLE);
   end

   // Grant, done, counter and rr pointer registers; req_len is only looked at on the grant edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pointer <= PW'(NREQ - 1);
         gnt     <= '0;
         done    <= '0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_vld) begin
                  gnt     <= win_oh;
                  count   <= lens[arb_win];
                  pointer <= arb_win;
               end
            end
            RUN: begin
               if (!req_held) begin
                  gnt   <= '0;
                  count <= '0;
               end else if (count != '0) begin
                  count <= count - WIDTH'(1);
               end else begin
                  done  <= gnt;
               end
            end
            default: begin
               gnt   <= '0;
               done  <= '0;
               count <= '0;
            end
         endcase
      end
   end

endmodule
